// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK operation encoding and next-state helper shared by the bank.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    jk_op_e op;
    op = jk_op_e'({j, k});
    case (op)
      JK_HOLD: return q;
      JK_CLR:  return 1'b0;
      JK_SET:  return 1'b1;
      JK_TGL:  return ~q;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - one JK bit with parallel load, enable and async active-low reset.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic d,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_next
);

  logic q_q;
  logic q_d;

  // load outranks the JK rule; with neither active the bit holds
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = jk_next(q_q, j, k);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign q_next = q_d;

endmodule

// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - bank of JK flag bits with per-bit change flags and a saturating change counter.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bits_q;
  logic [WIDTH-1:0] bits_next;
  logic [WIDTH-1:0] changed_q;
  logic [WIDTH-1:0] changed_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST_VAL(RST_VAL[i])
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .load  (load),
      .d     (d[i]),
      .j     (j[i]),
      .k     (k[i]),
      .q     (bits_q[i]),
      .q_next(bits_next[i])
    );
  end

  // clear wins over a same-edge increment; the counter sticks at its maximum
  always_comb begin
    changed_d = bits_next ^ bits_q;
    cnt_d     = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (|changed_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      changed_q <= '0;
      cnt_q     <= '0;
    end else begin
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign q       = bits_q;
  assign qb      = ~bits_q;
  assign changed = changed_q;
  assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb/tb_jk_reg_bank.sv - directed and randomized checks of jk_reg_bank (main: 16-bit counter, reset 0; aux: 2-bit counter, reset 3C).
module tb_jk_reg_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] d;
  logic [7:0] j;
  logic [7:0] k;
  logic       cnt_clr;

  logic [7:0]  q_a, qb_a, chg_a;
  logic [15:0] cnt_a;
  logic [7:0]  q_b, qb_b, chg_b;
  logic [1:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mq, mq2, mchg, mchg2;
  logic [15:0] mcnt;
  logic [1:0]  mcnt2;

  jk_reg_bank #(.WIDTH(8), .CNT_W(16), .RST_VAL(8'h00)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .j(j), .k(k),
    .cnt_clr(cnt_clr), .q(q_a), .qb(qb_a), .changed(chg_a), .chg_cnt(cnt_a)
  );

  jk_reg_bank #(.WIDTH(8), .CNT_W(2), .RST_VAL(8'h3C)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .j(j), .k(k),
    .cnt_clr(cnt_clr), .q(q_b), .qb(qb_b), .changed(chg_b), .chg_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] eq, input logic [7:0] ech,
                       input logic [15:0] ecnt);
    chk({tag, ".a.q"},   {24'd0, q_a},   {24'd0, eq});
    chk({tag, ".a.qb"},  {24'd0, qb_a},  {24'd0, ~eq});
    chk({tag, ".a.chg"}, {24'd0, chg_a}, {24'd0, ech});
    chk({tag, ".a.cnt"}, {16'd0, cnt_a}, {16'd0, ecnt});
  endtask

  task automatic chk_b(input string tag, input logic [7:0] eq, input logic [7:0] ech,
                       input logic [1:0] ecnt);
    chk({tag, ".b.q"},   {24'd0, q_b},   {24'd0, eq});
    chk({tag, ".b.qb"},  {24'd0, qb_b},  {24'd0, ~eq});
    chk({tag, ".b.chg"}, {24'd0, chg_b}, {24'd0, ech});
    chk({tag, ".b.cnt"}, {30'd0, cnt_b}, {30'd0, ecnt});
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] cur);
    logic [7:0] r;
    r = cur;
    if (load) begin
      r = d;
    end else if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (j[i] && k[i])      r[i] = ~cur[i];
        else if (j[i])         r[i] = 1'b1;
        else if (k[i])         r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic tick();
    logic [7:0] nq, nq2;
    nq  = model_next(mq);
    nq2 = model_next(mq2);
    @(posedge clk);
    #1;
    mchg  = nq ^ mq;
    mchg2 = nq2 ^ mq2;
    if (cnt_clr) mcnt = '0;
    else if ((mchg != 0) && (mcnt != 16'hFFFF)) mcnt = mcnt + 16'd1;
    if (cnt_clr) mcnt2 = '0;
    else if ((mchg2 != 0) && (mcnt2 != 2'd3)) mcnt2 = mcnt2 + 2'd1;
    mq  = nq;
    mq2 = nq2;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; load = 1'b0; d = 8'h00; j = 8'hFF; k = 8'hFF; cnt_clr = 1'b0;
    mq = 8'h00; mq2 = 8'h3C; mchg = '0; mchg2 = '0; mcnt = '0; mcnt2 = '0;

    // reset held while toggle inputs and clock are active
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_a("rst_hold", 8'h00, 8'h00, 16'd0);
      chk_b("rst_hold", 8'h3C, 8'h00, 2'd0);
    end
    rst = 1'b1;
    #1;
    chk_a("rst_rel", 8'h00, 8'h00, 16'd0);
    tick();
    chk_a("first_tgl", 8'hFF, 8'hFF, 16'd1);
    chk_b("first_tgl", 8'hC3, 8'hFF, 2'd1);

    // reset asserted between edges takes effect immediately
    rst = 1'b0;
    #1;
    chk_a("async_rst1", 8'h00, 8'h00, 16'd0);
    chk_b("async_rst1", 8'h3C, 8'h00, 2'd0);
    rst = 1'b1; j = 8'hF0; k = 8'h0F;
    tick();
    chk_a("set_clr", 8'hF0, 8'hF0, 16'd1);
    chk_b("set_clr", 8'hF0, 8'hCC, 2'd1);
    j = 8'hFF; k = 8'hFF;
    tick();
    chk_a("tgl_all", 8'h0F, 8'hFF, 16'd2);
    chk_b("tgl_all", 8'h0F, 8'hFF, 2'd2);

    // load beats JK, equal value gives no change
    load = 1'b1; d = 8'h0F;
    tick();
    chk_a("load_eq", 8'h0F, 8'h00, 16'd2);
    chk_b("load_eq", 8'h0F, 8'h00, 2'd2);
    load = 1'b0; en = 1'b0; j = 8'hFF; k = 8'h00;
    tick();
    chk_a("en_off", 8'h0F, 8'h00, 16'd2);

    // counter clear on a hold edge, then saturation of the 2-bit counter
    cnt_clr = 1'b1;
    tick();
    chk_a("clr_hold", 8'h0F, 8'h00, 16'd0);
    chk_b("clr_hold", 8'h0F, 8'h00, 2'd0);
    cnt_clr = 1'b0; en = 1'b1; j = 8'hFF; k = 8'hFF;
    tick(); chk_a("sat1", 8'hF0, 8'hFF, 16'd1); chk_b("sat1", 8'hF0, 8'hFF, 2'd1);
    tick(); chk_a("sat2", 8'h0F, 8'hFF, 16'd2); chk_b("sat2", 8'h0F, 8'hFF, 2'd2);
    tick(); chk_a("sat3", 8'hF0, 8'hFF, 16'd3); chk_b("sat3", 8'hF0, 8'hFF, 2'd3);
    tick(); chk_a("sat4", 8'h0F, 8'hFF, 16'd4); chk_b("sat4", 8'h0F, 8'hFF, 2'd3);
    tick(); chk_a("sat5", 8'hF0, 8'hFF, 16'd5); chk_b("sat5", 8'hF0, 8'hFF, 2'd3);
    cnt_clr = 1'b1;
    tick();
    chk_a("clr_tgl", 8'h0F, 8'hFF, 16'd0);
    chk_b("clr_tgl", 8'h0F, 8'hFF, 2'd0);
    cnt_clr = 1'b0;

    // mid-cycle reset from a loaded A5
    load = 1'b1; en = 1'b0; d = 8'hA5;
    tick();
    chk_a("load_a5", 8'hA5, 8'hAA, 16'd1);
    chk_b("load_a5", 8'hA5, 8'hAA, 2'd1);
    load = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk_a("async_rst2", 8'h00, 8'h00, 16'd0);
    chk_b("async_rst2", 8'h3C, 8'h00, 2'd0);
    #1;
    rst = 1'b1;
    mq = 8'h00; mq2 = 8'h3C; mcnt = '0; mcnt2 = '0;

    // randomized traffic against the bench model
    for (int c = 0; c < 1000; c++) begin
      en      = 1'($urandom_range(0, 3) != 0);
      load    = 1'($urandom_range(0, 7) == 0);
      cnt_clr = 1'($urandom_range(0, 15) == 0);
      d       = 8'($urandom);
      j       = 8'($urandom);
      k       = 8'($urandom);
      tick();
      chk_a("rand", mq, mchg, mcnt);
      chk_b("rand", mq2, mchg2, mcnt2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
